// File: rtl/rr_merge.sv
// ---------------------------------------------------------------------------
// rr_merge
//
// Round-robin N-to-1 merge stage that sits in front of the address-decoded
// split on the native interconnect bus.
//
// Several masters present request words. One master at a time is granted the
// downstream path, and it keeps the grant for a whole transaction, from valid
// until the slave's ready. The request word of the granted master is passed
// straight through to the split. The single response word coming back is
// routed to the granted master only.
//
// Arbitration is strict rotation. The scan starts at ptr_q, and ptr_q moves
// one past the master whose transaction completed. A request that is
// abandoned before ready leaves ptr_q where it was.
//
// Request word layout (valid is always the MSB):
//   TYPE "D" : {valid, addr[ADDR_W-1:0], wdata[31:0], wstrb[3:0]}
//   TYPE "I" : {valid, addr[ADDR_W-1:0]}
// Response word layout: {rdata[31:0], ready}. ready is the LSB.
//
// Ports:
//   clk     in   1                   system clock, rising edge
//   rst     in   1                   synchronous, active-high reset
//   m_req   in   N_MASTERS*REQ_W     master request words, master i at
//                                    [(i+1)*REQ_W-1 : i*REQ_W]
//   m_resp  out  N_MASTERS*RESP_W    master response words, same slicing
//   s_req   out  REQ_W               request word to the downstream split
//   s_resp  in   RESP_W              response word from the downstream split
// ---------------------------------------------------------------------------
module rr_merge #(
    parameter logic [7:0] TYPE      = "D",
    parameter int         N_MASTERS = 2,
    parameter int         ADDR_W    = 32,
    localparam int        REQ_W     = (TYPE == "I") ? (1 + ADDR_W) : (1 + ADDR_W + 36),
    localparam int        RESP_W    = 33
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp
);

    localparam int GW = $clog2(N_MASTERS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [GW-1:0] ptr_q, ptr_d;

    logic [REQ_W-1:0]     req_words [N_MASTERS];
    logic [N_MASTERS-1:0] req_valid;

    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic          gnt_valid;
    logic          resp_ready;

    // Index that lies 'offset' positions after 'base', wrapping at
    // N_MASTERS. This also works when N_MASTERS is not a power of two.
    function automatic logic [GW-1:0] rot_idx(input logic [GW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= N_MASTERS) begin
            sum = sum - N_MASTERS;
        end
        return GW'(sum);
    endfunction

    // Successor of a master index, wrapping from N_MASTERS-1 back to 0.
    function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] idx);
        if (int'(idx) == N_MASTERS - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Split the flat request bus into one word per master, and pull out
    // the valid bit of each word.
    for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
        assign req_words[i] = m_req[i*REQ_W +: REQ_W];
        assign req_valid[i] = req_words[i][REQ_W-1];
    end

    assign gnt_valid  = req_valid[gnt_q];
    assign resp_ready = s_resp[0];

    // Rotating priority pick. The loop walks from the lowest-priority
    // offset to the highest. Each valid master overwrites the previous
    // choice, so the valid master closest to ptr_q wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (req_valid[rot_idx(ptr_q, k)]) begin
                pick_found = 1'b1;
                pick_idx   = rot_idx(ptr_q, k);
            end
        end
    end

    // State, grant and pointer registers. Reset returns to IDLE with
    // master 0 first in line. A reset taken in BUSY drops the
    // transaction, so no later ready is forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic.
    // If ready and a dropped valid arrive together, ready takes priority:
    // the transaction counts as complete and the pointer advances.
    // Only a drop with no ready counts as an abandon, and it leaves the
    // pointer alone.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    gnt_d   = pick_idx;
                end
            end
            BUSY: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    ptr_d   = wrap_inc(gnt_q);
                end else if (!gnt_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output routing. Only BUSY opens a path, and only for the granted
    // master. In IDLE both directions are forced to zero, so a stray
    // ready from the slave never reaches any master.
    always_comb begin
        s_req  = '0;
        m_resp = '0;
        if (state_q == BUSY) begin
            s_req = req_words[gnt_q];
            for (int i = 0; i < N_MASTERS; i++) begin
                if (int'(gnt_q) == i) begin
                    m_resp[i*RESP_W +: RESP_W] = s_resp;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_merge.sv
// ---------------------------------------------------------------------------
// tb_rr_merge
//
// Testbench for rr_merge with three masters on a data-type bus.
//
// The stimulus process drives the masters and the slave. For every cycle it
// asks a transaction-level reference model for the expected s_req and m_resp,
// and pushes that expectation into a queue. A separate monitor pops one
// expectation on each falling clock edge and compares it with the DUT.
//
// The monitor also records the order of grants it sees on s_req. Directed
// scenarios check that order against fixed sequences.
// ---------------------------------------------------------------------------
module tb_rr_merge;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int RW = 1 + AW + 36;
    localparam int SW = 33;

    logic clk = 1'b0;
    logic rst;

    logic [NM*RW-1:0] mReqBus;
    logic [NM*SW-1:0] mRespBus;
    logic [RW-1:0]    sReq;
    logic [SW-1:0]    sRespBus;

    logic        mValid [NM];
    logic [31:0] mAddr  [NM];
    logic [31:0] mWdata [NM];
    logic [3:0]  mWstrb [NM];
    logic        sReady;
    logic [31:0] sRdata;

    typedef struct {
        logic [RW-1:0]    sReq;
        logic [NM*SW-1:0] mResp;
    } expect_t;

    expect_t expQ [$];
    int      dutGrants [$];
    int      wantGrants [$];

    int errorCount = 0;
    int checkCount = 0;

    // Reference model state. mOwner is the granted master, or -1 when no
    // master is granted.
    int mOwner = -1;
    int mPtr   = 0;
    int doneMaster = -1;

    logic prevValid = 1'b0;

    rr_merge #(
        .TYPE     ("D"),
        .N_MASTERS(NM),
        .ADDR_W   (AW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .m_req (mReqBus),
        .m_resp(mRespBus),
        .s_req (sReq),
        .s_resp(sRespBus)
    );

    always #5 clk = ~clk;

    // Pack each master's request fields into the flat request bus.
    always_comb begin
        mReqBus = '0;
        for (int i = 0; i < NM; i++) begin
            mReqBus[i*RW +: RW] = {mValid[i], mAddr[i], mWdata[i], mWstrb[i]};
        end
    end

    assign sRespBus = {sRdata, sReady};

    // Build the request word of master i from the fields the bench drives.
    function automatic logic [RW-1:0] reqWord(input int i);
        return {mValid[i], mAddr[i], mWdata[i], mWstrb[i]};
    endfunction

    // Return the master whose driven word matches s_req, or -1 if none does.
    function automatic int grantedIndex();
        for (int i = 0; i < NM; i++) begin
            if (reqWord(i) === sReq) return i;
        end
        return -1;
    endfunction

    // Compare one value and report it. Each call counts as one check.
    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference model, combinational view.
    // The granted master's word goes downstream, and the slave response goes
    // back to that master only. With no grant, every output is zero.
    function automatic void pushExpect();
        expect_t e;
        e.sReq  = '0;
        e.mResp = '0;
        if (mOwner >= 0) begin
            e.sReq = reqWord(mOwner);
            e.mResp[mOwner*SW +: SW] = {sRdata, sReady};
        end
        expQ.push_back(e);
    endfunction

    // Reference model, clock-edge view. It uses the inputs present during
    // the cycle that is ending.
    function automatic void modelUpdate();
        doneMaster = -1;
        if (rst) begin
            mOwner = -1;
            mPtr   = 0;
        end else if (mOwner < 0) begin
            for (int k = 0; k < NM; k++) begin
                int cand;
                cand = (mPtr + k) % NM;
                if (mOwner < 0 && mValid[cand]) mOwner = cand;
            end
        end else if (sReady) begin
            doneMaster = mOwner;
            mPtr       = (mOwner + 1) % NM;
            mOwner     = -1;
        end else if (!mValid[mOwner]) begin
            mOwner = -1;
        end
    endfunction

    // Run one clock cycle with the inputs currently driven. The task returns
    // 1 time unit after the rising edge, which is when new inputs are driven.
    task automatic applyStimulus(input bit check = 1'b1);
        if (check) pushExpect();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    // Set every master's valid bit from one vector.
    task automatic setValids(input logic [NM-1:0] v);
        for (int i = 0; i < NM; i++) mValid[i] = v[i];
    endtask

    // Compare the grant order seen by the monitor with the wanted order,
    // then clear both lists.
    task automatic checkGrants(input string name);
        checkOutput({name, " count"}, 128'(dutGrants.size()), 128'(wantGrants.size()));
        for (int i = 0; i < wantGrants.size() && i < dutGrants.size(); i++) begin
            checkOutput($sformatf("%s[%0d]", name, i), 128'(dutGrants[i]), 128'(wantGrants[i]));
        end
        dutGrants.delete();
        wantGrants.delete();
    endtask

    // Monitor. On each falling edge it compares the DUT outputs with the
    // next expectation, and logs each new grant (a rising s_req valid).
    always @(negedge clk) begin
        expect_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("s_req", 128'(sReq), 128'(e.sReq));
            checkOutput("m_resp", 128'(mRespBus), 128'(e.mResp));
        end
        if (sReq[RW-1] === 1'b1 && prevValid === 1'b0) begin
            dutGrants.push_back(grantedIndex());
        end
        prevValid = sReq[RW-1];
    end

    initial begin
        rst    = 1'b1;
        sReady = 1'b0;
        sRdata = '0;
        for (int i = 0; i < NM; i++) begin
            mValid[i] = 1'b1;
            mAddr[i]  = 32'(i + 1) << 12;
            mWdata[i] = $urandom;
            mWstrb[i] = 4'hF;
        end

        @(posedge clk);
        #1;

        // First reset cycle. DUT state is unknown until the first edge
        // with reset asserted, so this cycle is not compared.
        applyStimulus(1'b0);

        // Reset held for a second cycle while all masters request. After
        // release, the first grant goes to master 0.
        $display("[TB] reset scenario");
        dutGrants.delete();
        applyStimulus();
        rst = 1'b0;
        applyStimulus();
        sReady = 1'b1;
        sRdata = 32'hA5A5_0001;
        applyStimulus();
        setValids(3'b000);
        sReady = 1'b0;
        applyStimulus();
        wantGrants.push_back(0);
        checkGrants("resetFirstGrant");

        // Single master 1 with a three-cycle slave.
        $display("[TB] single master scenario");
        mAddr[1]  = 32'h0000_0100;
        mWstrb[1] = 4'hF;
        mWdata[1] = 32'hDEAD_BEEF;
        mValid[1] = 1'b1;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        sReady = 1'b1;
        sRdata = 32'h1234_5678;
        applyStimulus();
        mValid[1] = 1'b0;
        sReady    = 1'b0;
        applyStimulus();
        wantGrants.push_back(1);
        checkGrants("singleMaster");

        // All three masters request against a zero-wait slave. The pointer
        // currently sits at 2, so grants go 2, 0, 1, 2, 0, 1.
        $display("[TB] rotation scenario");
        mAddr[1] = 32'h0000_2000;
        setValids(3'b111);
        sReady = 1'b1;
        for (int c = 0; c < 12; c++) begin
            sRdata = $urandom;
            applyStimulus();
        end
        for (int k = 0; k < 6; k++) wantGrants.push_back((2 + k) % NM);
        checkGrants("rotation");

        // Wrap case. The pointer is at 2 and only masters 0 and 2 request,
        // so grants go 2 then 0. The pointer then returns to 1.
        $display("[TB] wrap scenario");
        setValids(3'b101);
        for (int c = 0; c < 4; c++) begin
            sRdata = $urandom;
            applyStimulus();
        end
        setValids(3'b111);
        for (int c = 0; c < 2; c++) begin
            sRdata = $urandom;
            applyStimulus();
        end
        wantGrants.push_back(2);
        wantGrants.push_back(0);
        wantGrants.push_back(1);
        checkGrants("wrap");

        // Abandon case. Master 1 drops valid before ready. A late ready from
        // the slave must go nowhere, and the pointer must still be 2.
        $display("[TB] abandon scenario");
        setValids(3'b010);
        sReady = 1'b0;
        applyStimulus();
        applyStimulus();
        mValid[1] = 1'b0;
        applyStimulus();
        sReady = 1'b1;
        sRdata = 32'hBAD0_BAD0;
        applyStimulus();
        sReady = 1'b0;
        setValids(3'b111);
        applyStimulus();
        sReady = 1'b1;
        sRdata = $urandom;
        applyStimulus();
        wantGrants.push_back(1);
        wantGrants.push_back(2);
        checkGrants("abandon");

        // Reset in the middle of a transaction. The ready that arrives next
        // is dropped, and arbitration restarts from master 0.
        $display("[TB] mid-transaction reset scenario");
        setValids(3'b010);
        sReady = 1'b0;
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        setValids(3'b111);
        sReady = 1'b1;
        sRdata = 32'hFEED_F00D;
        applyStimulus();
        sRdata = $urandom;
        applyStimulus();
        setValids(3'b000);
        sReady = 1'b0;
        applyStimulus();
        wantGrants.push_back(1);
        wantGrants.push_back(0);
        checkGrants("midReset");

        // Random traffic. Masters raise requests at random and hold them
        // until completion. The owner sometimes abandons its request. The
        // slave answers at random, including in IDLE cycles, and reset is
        // pulsed now and then.
        $display("[TB] random scenario");
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 255) == 0);
            for (int i = 0; i < NM; i++) begin
                if (i == doneMaster) begin
                    mValid[i] = ($urandom_range(0, 1) == 1);
                    mAddr[i]  = $urandom;
                    mWdata[i] = $urandom;
                    mWstrb[i] = 4'($urandom_range(0, 15));
                end else if (!mValid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        mValid[i] = 1'b1;
                        mAddr[i]  = $urandom;
                        mWdata[i] = $urandom;
                        mWstrb[i] = 4'($urandom_range(0, 15));
                    end
                end else if (i == mOwner && $urandom_range(0, 15) == 0) begin
                    mValid[i] = 1'b0;
                end
            end
            sReady = ($urandom_range(0, 3) == 0);
            sRdata = $urandom;
            applyStimulus();
        end
        rst = 1'b0;
        setValids(3'b000);
        sReady = 1'b0;
        applyStimulus();
        dutGrants.delete();

        checkOutput("expQ drained", 128'(expQ.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rr_merge.md
# rr_merge

Round-robin N-to-1 merge stage for the native interconnect bus. It sits directly upstream of the address-decoded split: several masters' request words come in, one request word goes out to the split's master port, and the single response is routed back to the granted master. Grant is registered and held for a whole transaction (valid until ready), so one master owns the downstream path at a time.

## Interface
- TYPE, D: bus flavour; D = data bus with request word {valid, addr, wdata[31:0], wstrb[3:0]}, I = instruction bus with request word {valid, addr}; valid is the MSB of every request word.
- N_MASTERS, 2: number of upstream masters, 2..16.
- ADDR_W, 32: address field width inside the request word.
- REQ_W, derived: 1+ADDR_W+36 (D) or 1+ADDR_W (I).
- RESP_W, derived: 33; response word {rdata[31:0], ready}, ready is the LSB.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- m_req  in  N_MASTERS*REQ_W  master request words; master i occupies bits [(i+1)*REQ_W-1 : i*REQ_W].
- m_resp  out  N_MASTERS*RESP_W  master response words, same slicing with RESP_W.
- s_req  out  REQ_W  request word to the downstream split.
- s_resp  in  RESP_W  response word from the downstream split.

## Operation
- State: IDLE / BUSY. Registers: state, gnt (clog2(N_MASTERS) bits), ptr (same width, next-priority index).
- IDLE: scan masters ptr, ptr+1, …, wrapping modulo N_MASTERS. The first with valid=1 is captured into gnt and state becomes BUSY. No valid means stay IDLE.
- BUSY: s_req = m_req slice gnt, passed through combinationally. m_resp slice gnt = s_resp. All other m_resp slices are all-zero.
- BUSY and s_resp.ready=1: transaction ends. Next state is IDLE and ptr becomes (gnt+1) mod N_MASTERS. Wrap from N_MASTERS-1 goes to 0.
- BUSY and the granted master's valid=0 with ready=0 (abandoned request): next state is IDLE and ptr is unchanged.
- IDLE: s_req is all-zero and every m_resp slice is all-zero. An s_resp.ready seen in IDLE is ignored and not forwarded.
- Non-granted masters' requests are never forwarded. They wait, holding valid, until granted.
- Masters are never reordered within themselves; fairness is strict rotation. Worst-case wait is N_MASTERS-1 complete transactions plus one arbitration cycle each.

## Timing
- Reset (rst=1 at an edge): state=IDLE, gnt=0, ptr=0. From the following cycle, s_req=0 and all m_resp=0. Reset during BUSY aborts the transaction; no ready is forwarded afterwards.
- Arbitration latency is 1 cycle. Valid sampled in IDLE at edge k gives s_req valid during cycle k+1.
- Ready is combinational pass-through. Slave ready in cycle n gives the granted master ready in cycle n, with rdata valid in the same cycle.
- After ready, there is exactly one IDLE cycle (s_req.valid=0) before the next grant. Back-to-back transactions therefore issue at best every (slave latency + 2) cycles.
- A zero-wait slave (ready in the first BUSY cycle) still gives a 2-cycle transaction: grant cycle plus BUSY cycle.
- Simultaneous requests are resolved only by ptr. A lower index has no fixed priority.

## Test plan
- Reset: hold rst=1 for 2 cycles while all masters have valid=1 -> s_req=0 and m_resp=0 during reset and the cycle after release; the first grant goes to master 0.
- Single master: N_MASTERS=3; master 1 issues addr 0x100, wstrb=0xF, wdata=0xDEADBEEF; slave gives ready at the 3rd BUSY cycle with rdata=0x12345678 -> s_req equals master 1's word for 3 cycles; master 1 sees ready and rdata in that cycle; masters 0 and 2 see 0.
- Rotation: masters 0, 1 and 2 all hold valid; slave is zero-wait -> grants run 0,1,2,0,…, one transaction per 2 cycles; no master gets two grants in a row.
- Wrap: ptr=2 and only masters 0 and 2 request -> grant 2, then 0; ptr returns to 1 after master 0's ready.
- Abandon: master 1 is granted and drops valid before ready -> IDLE next cycle, ptr unchanged; a late slave ready is not forwarded to any master.
- Mid-transaction reset: rst pulses 1 cycle during BUSY with slave ready arriving the next cycle -> ready is not forwarded; state=IDLE; the next grant follows the ptr=0 order.
